// File: rtl/smem_axi4l_master_bridge.sv
// Bridges single-outstanding SimpleMemory requests onto an AXI4-Lite master port.
// Every handshake output is registered; one transaction is in flight at a time.
module smem_axi4l_master_bridge #(
  parameter logic [2:0] AXI_PROT   = 3'b000,
  parameter bit         ALIGN_ADDR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awprot_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  output logic [2:0]  arprot_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK} state_t;

  state_t      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ready_d, err_d;
  logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [31:0] awaddr_d, araddr_d, wdata_d, rdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] req_addr;
  logic        aw_hs, w_hs;
  logic        unused_resp_lsb;

  // Only bit 1 of a response (SLVERR/DECERR) is reported as an error.
  assign unused_resp_lsb = &{1'b0, bresp_i[0], rresp_i[0]};

  assign req_addr = ALIGN_ADDR ? {addr_i[31:2], 2'b00} : addr_i;
  assign aw_hs    = awvalid_o & awready_i;
  assign w_hs     = wvalid_o & wready_i;
  assign awprot_o = AXI_PROT;
  assign arprot_o = AXI_PROT;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    awvalid_d = awvalid_o;
    wvalid_d  = wvalid_o;
    bready_d  = bready_o;
    arvalid_d = arvalid_o;
    rready_d  = rready_o;
    awaddr_d  = awaddr_o;
    araddr_d  = araddr_o;
    wdata_d   = wdata_o;
    wstrb_d   = wstrb_o;
    rdata_d   = rdata_o;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (wstrb_i != 4'b0000) begin
            awaddr_d  = req_addr;
            wdata_d   = wdata_i;
            wstrb_d   = wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; B is only accepted once both are done.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        awvalid_d = awvalid_o & ~awready_i;
        wvalid_d  = wvalid_o & ~wready_i;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = bresp_i[1];
          state_d  = ACK;
        end
      end
      RD_REQ: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid_i) begin
          rdata_d  = rdata_i;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = rresp_i[1];
          state_d  = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_o   <= 1'b0;
      err_o     <= 1'b0;
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awaddr_o  <= '0;
      araddr_o  <= '0;
      wdata_o   <= '0;
      wstrb_o   <= '0;
      rdata_o   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_o   <= ready_d;
      err_o     <= err_d;
      awvalid_o <= awvalid_d;
      wvalid_o  <= wvalid_d;
      bready_o  <= bready_d;
      arvalid_o <= arvalid_d;
      rready_o  <= rready_d;
      awaddr_o  <= awaddr_d;
      araddr_o  <= araddr_d;
      wdata_o   <= wdata_d;
      wstrb_o   <= wstrb_d;
      rdata_o   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_smem_axi4l_master_bridge.sv
// Bench for smem_axi4l_master_bridge: AXI slave with configurable delays, a
// channel-level reference model compared every cycle, plus directed scenarios.
module tb_smem_axi4l_master_bridge;

  logic        clk_i, rst_i, valid_i, ready_o, err_o;
  logic [3:0]  wstrb_i;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0]  awprot_o, arprot_o;
  logic [3:0]  wstrb_o;
  logic [1:0]  bresp_i, rresp_i;

  smem_axi4l_master_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .wstrb_i(wstrb_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .err_o(err_o), .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .awprot_o(awprot_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // slave configuration, written only by the stimulus process
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  bit          stray_en = 1'b0;

  // monitor observations, written only by the monitor process
  int          aw_hs_cnt = 0, ar_hs_cnt = 0, ready_cnt = 0, awv_cyc = 0, wv_cyc = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;

  // reference model: which channels are outstanding, what the bridge must present
  bit          model_ok = 0, busy = 0, wr_phase = 0;
  bit          aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0, ack_pend = 0, ack_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, last_rd = 0;
  logic [3:0]  m_wstrb = 0;

  // Monitor, AXI slave and model all act on the falling edge.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_got, w_got, b_owed, r_owed;
    bit mhs_aw, mhs_w, mhs_b, mhs_ar, mhs_r;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
    awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
    bresp_i = 0; rresp_i = 0; rdata_i = 0;
    forever begin
      @(negedge clk_i);
      if (model_ok) begin
        chk("awvalid", awvalid_o, aw_pend);
        chk("wvalid", wvalid_o, w_pend);
        chk("bready", bready_o, b_pend);
        chk("arvalid", arvalid_o, ar_pend);
        chk("rready", rready_o, r_pend);
        chk("ready", ready_o, ack_pend);
        chk("err", err_o, ack_pend && ack_err);
        chk("rdata_hold", rdata_o, last_rd);
        chk("prot", {awprot_o, arprot_o}, 6'b0);
        if (aw_pend) chk("awaddr", awaddr_o, m_addr);
        if (w_pend) begin
          chk("wdata", wdata_o, m_wdata);
          chk("wstrb", wstrb_o, m_wstrb);
        end
        if (ar_pend) chk("araddr", araddr_o, m_addr);
      end
      if (ready_o) ready_cnt++;
      if (awvalid_o) awv_cyc++;
      if (wvalid_o) wv_cyc++;

      // AXI slave
      if (rst_i) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0;
        awready_i = 0; wready_i = 0; arready_i = 0; bvalid_i = 0; rvalid_i = 0;
        bresp_i = 0; rresp_i = 0; rdata_i = 0;
      end else begin
        awready_i = awvalid_o && (aw_wait >= cfg_aw_dly);
        wready_i  = wvalid_o && (w_wait >= cfg_w_dly);
        arready_i = arvalid_o && (ar_wait >= cfg_ar_dly);
        bvalid_i  = b_owed && (b_wait >= cfg_b_dly);
        bresp_i   = bvalid_i ? cfg_bresp : 2'b00;
        rvalid_i  = r_owed && (r_wait >= cfg_r_dly);
        rresp_i   = rvalid_i ? cfg_rresp : 2'b00;
        rdata_i   = rvalid_i ? cfg_rdata : 32'h0;
        if (stray_en && !b_owed && !r_owed && !aw_got && !w_got && !awvalid_o && !wvalid_o &&
            !arvalid_o && $urandom_range(3) == 0) begin
          bvalid_i = 1; rvalid_i = 1; bresp_i = 2'b10; rresp_i = 2'b10; rdata_i = $urandom;
        end
        if (awvalid_o && !awready_i) aw_wait++;
        if (wvalid_o && !wready_i) w_wait++;
        if (arvalid_o && !arready_i) ar_wait++;
        if (b_owed && !bvalid_i) b_wait++;
        if (r_owed && !rvalid_i) r_wait++;
        if (awvalid_o && awready_i) begin
          aw_got = 1; aw_wait = 0; cap_awaddr = awaddr_o; aw_hs_cnt++;
        end
        if (wvalid_o && wready_i) begin
          w_got = 1; w_wait = 0; cap_wdata = wdata_o;
        end
        if (arvalid_o && arready_i) begin
          r_owed = 1; r_wait = 0; ar_wait = 0; cap_araddr = araddr_o; ar_hs_cnt++;
        end
        if (bvalid_i && bready_o) b_owed = 0;
        if (rvalid_i && rready_o) r_owed = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_owed = 1; b_wait = 0;
        end
      end

      // model advance across the coming rising edge
      if (rst_i) begin
        model_ok = 1; busy = 0; wr_phase = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0; ack_pend = 0;
        last_rd = 0;
      end else if (model_ok) begin
        mhs_aw = aw_pend && awready_i;
        mhs_w  = w_pend && wready_i;
        mhs_b  = b_pend && bvalid_i;
        mhs_ar = ar_pend && arready_i;
        mhs_r  = r_pend && rvalid_i;
        if (ack_pend) begin
          ack_pend = 0; busy = 0;
        end else if (!busy && valid_i) begin
          busy = 1;
          m_addr = {addr_i[31:2], 2'b00};
          if (wstrb_i != 4'b0000) begin
            wr_phase = 1; aw_pend = 1; w_pend = 1; m_wdata = wdata_i; m_wstrb = wstrb_i;
          end else begin
            ar_pend = 1;
          end
        end
        if (mhs_aw) aw_pend = 0;
        if (mhs_w) w_pend = 0;
        if (wr_phase && !aw_pend && !w_pend) begin
          wr_phase = 0; b_pend = 1;
        end
        if (mhs_b) begin
          b_pend = 0; ack_pend = 1; ack_err = bresp_i[1];
        end
        if (mhs_ar) begin
          ar_pend = 0; r_pend = 1;
        end
        if (mhs_r) begin
          r_pend = 0; ack_pend = 1; ack_err = rresp_i[1]; last_rd = rdata_i;
        end
      end
    end
  end

  task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
    cfg_aw_dly = aw; cfg_w_dly = w; cfg_ar_dly = ar; cfg_b_dly = b; cfg_r_dly = r;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
  endtask

  // Presents a request and waits for ready_o; valid_i is left high on return.
  task automatic do_req(input logic [3:0] strb, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd);
    bit got;
    @(posedge clk_i); #1;
    valid_i = 1; wstrb_i = strb; addr_i = a; wdata_i = d;
    lat = 0; e = 0; rd = 0; got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) begin
        e = err_o; rd = rdata_o; got = 1;
        break;
      end
      lat++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_timeout: no ready_o for addr %h within 300 cycles", a);
    end
  endtask

  task automatic drop_req();
    @(posedge clk_i); #1;
    valid_i = 0; wstrb_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, base_aw, base_w, base_rdy, base_awhs, base_arhs;
    logic e, e2;
    logic [31:0] rd, rd2, a;
    logic [3:0] s;
    bit got;
    rst_i = 1; valid_i = 0; wstrb_i = 0; addr_i = 0; wdata_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", awaddr_o | araddr_o | wdata_o, 32'h0);
    chk("rst_ctrl", {ready_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 7'b0);

    // plain write, immediate slave
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_req(4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, lat, e, rd);
    chk("wr_latency", lat, 3);
    chk("wr_awaddr", cap_awaddr, 32'h0000_1004);
    chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("wr_err", e, 0);
    drop_req();

    // read from unaligned address
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1234_5678);
    do_req(4'b0000, 32'h0000_2003, 32'h0, lat, e, rd);
    chk("rd_latency", lat, 3);
    chk("rd_araddr", cap_araddr, 32'h0000_2000);
    chk("rd_rdata", rd, 32'h1234_5678);
    chk("rd_err", e, 0);
    drop_req();

    // wready five cycles late
    base_aw = awv_cyc; base_w = wv_cyc; base_rdy = ready_cnt;
    set_slave(0, 5, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_req(4'b0011, 32'h0000_3000, 32'hA5A5_0F0F, lat, e, rd);
    drop_req();
    chk("slow_w_awvalid_cycles", awv_cyc - base_aw, 1);
    chk("slow_w_wvalid_cycles", wv_cyc - base_w, 6);
    chk("slow_w_ready_pulses", ready_cnt - base_rdy, 1);
    chk("slow_w_latency", lat, 8);

    // read error with late rvalid, then a clean write
    base_rdy = ready_cnt;
    set_slave(0, 0, 0, 0, 3, 2'b00, 2'b10, 32'hCAFE_F00D);
    do_req(4'b0000, 32'h0000_4000, 32'h0, lat, e, rd);
    drop_req();
    chk("rderr_err", e, 1);
    chk("rderr_rdata", rd, 32'hCAFE_F00D);
    chk("rderr_ready_pulses", ready_cnt - base_rdy, 1);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_req(4'b1000, 32'h0000_4100, 32'h0102_0304, lat, e, rd);
    drop_req();
    chk("after_rderr_err", e, 0);
    chk("after_rderr_rdata", rd, 32'hCAFE_F00D);

    // back-to-back read then write, valid_i never dropped
    base_rdy = ready_cnt; base_awhs = aw_hs_cnt; base_arhs = ar_hs_cnt;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h1111_2222);
    do_req(4'b0000, 32'h0000_5000, 32'h0, lat, e, rd);
    do_req(4'b1111, 32'h0000_5004, 32'h3333_4444, lat2, e2, rd2);
    drop_req();
    chk("b2b_ar_count", ar_hs_cnt - base_arhs, 1);
    chk("b2b_aw_count", aw_hs_cnt - base_awhs, 1);
    chk("b2b_ready_pulses", ready_cnt - base_rdy, 2);
    chk("b2b_rdata", rd, 32'h1111_2222);
    chk("b2b_wdata", cap_wdata, 32'h3333_4444);

    // reset while waiting for B
    set_slave(0, 0, 0, 20, 0, 2'b00, 2'b00, 32'h0);
    @(posedge clk_i); #1;
    valid_i = 1; wstrb_i = 4'b1111; addr_i = 32'h0000_6000; wdata_i = 32'h5555_AAAA;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bready_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("rst_mid_reached_bready", got, 1);
    @(posedge clk_i); #1;
    rst_i = 1; valid_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("rst_mid_ctrl", {ready_o, err_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 7'b0);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h7777_8888);
    do_req(4'b0000, 32'h0000_7008, 32'h0, lat, e, rd);
    drop_req();
    chk("post_rst_rdata", rd, 32'h7777_8888);
    chk("post_rst_araddr", cap_araddr, 32'h0000_7008);
    chk("post_rst_err", e, 0);

    // randomized traffic with stray B/R pulses while idle
    stray_en = 1;
    for (int n = 0; n < 60; n++) begin
      set_slave($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                $urandom_range(3), {1'($urandom_range(1)), 1'b0}, {1'($urandom_range(1)), 1'b0},
                $urandom);
      s = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
      a = $urandom;
      do_req(s, a, $urandom, lat, e, rd);
      if (s == 4'b0000) begin
        chk("rand_rd_err", e, cfg_rresp[1]);
        chk("rand_rd_data", rd, cfg_rdata);
        chk("rand_rd_addr", cap_araddr, {a[31:2], 2'b00});
      end else begin
        chk("rand_wr_err", e, cfg_bresp[1]);
        chk("rand_wr_addr", cap_awaddr, {a[31:2], 2'b00});
      end
      if ($urandom_range(1) == 0) begin
        drop_req();
        repeat ($urandom_range(3)) @(posedge clk_i);
      end
    end
    drop_req();
    stray_en = 0;
    repeat (4) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
